// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the RF write port between the pipeline writeback and a buffered long-latency result stream (optional same-cycle bypass: RF_ARB_BYPASS_EN)
module rf_write_arbiter #(
  parameter int W = 32,
  parameter int DEPTH = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pipe_we,
  input  logic [4:0]   pipe_addr,
  input  logic [W-1:0] pipe_data,
  input  logic         mc_valid,
  output logic         mc_ready,
  input  logic [4:0]   mc_addr,
  input  logic [W-1:0] mc_data,
  output logic         rf_we,
  output logic [4:0]   rf_waddr,
  output logic [W-1:0] rf_wdata,
  output logic         stall_pipe,
  output logic         mc_pending
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [4:0]    mem_addr [DEPTH];
  logic [W-1:0]  mem_data [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [SW-1:0] starve_cnt;
  logic empty, full, pipe_live, pop, push, byp;
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign pipe_live = pipe_we && pipe_addr != 5'd0 && !stall_pipe;
  assign pop = !pipe_live && !empty;
`ifdef RF_ARB_BYPASS_EN
  assign byp = mc_valid && empty && !pipe_live;
`else
  assign byp = 1'b0;
`endif
  assign push = mc_valid && mc_ready && !byp;
  assign mc_ready = !full;
  assign mc_pending = !empty;
  // A popped head or bypassed result addressed to r0 yields address 0, which suppresses the write
  always_comb begin
    rf_waddr = pipe_live ? pipe_addr : pop ? mem_addr[rd_ptr] : byp ? mc_addr : 5'd0;
    rf_wdata = pipe_live ? pipe_data : pop ? mem_data[rd_ptr] : byp ? mc_data : '0;
    rf_we = rf_waddr != 5'd0;
  end
  // FIFO storage, written on accepted pushes only
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr] <= mc_addr;
      mem_data[wr_ptr] <= mc_data;
    end
  end
  // FIFO pointers, occupancy, starvation counter and the one-cycle pipeline hold
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      starve_cnt <= '0;
      stall_pipe <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
      starve_cnt <= (pop || empty) ? '0 : starve_cnt + SW'(1);
      stall_pipe <= !stall_pipe && !empty && !pop && starve_cnt == SW'(STARVE_LIMIT - 1);
    end
  end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: scoreboard bench for rf_write_arbiter; long-latency results are queued at drive time and matched in order on retirement
module tb_rf_write_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pipe_we = 1'b0;
  logic [4:0]  pipe_addr = '0;
  logic [31:0] pipe_data = '0;
  logic        mc_valid = 1'b0;
  logic        mc_ready;
  logic [4:0]  mc_addr = '0;
  logic [31:0] mc_data = '0;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        stall_pipe;
  logic        mc_pending;
  logic        exp_pipe = 1'b0;
  int n_checks = 0;
  int n_fail = 0;
  typedef struct { logic [4:0] a; logic [31:0] d; } ent_t;
  ent_t sb[$];
  ent_t mon_e;

  rf_write_arbiter #(.W(32), .DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .pipe_we(pipe_we), .pipe_addr(pipe_addr), .pipe_data(pipe_data),
    .mc_valid(mc_valid), .mc_ready(mc_ready), .mc_addr(mc_addr), .mc_data(mc_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .stall_pipe(stall_pipe), .mc_pending(mc_pending)
  );

  always #5 clk = ~clk;

  // Any RF write not expected from the pipeline must be the oldest outstanding long-latency result
  always @(negedge clk) begin
    if (rf_we && !exp_pipe) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_mc_write: got addr=%0d data=%h, required no write", rf_waddr, rf_wdata);
      end else begin
        mon_e = sb.pop_front();
        if (rf_waddr !== mon_e.a || rf_wdata !== mon_e.d) begin
          n_fail++;
          $display("FAIL mc_retire_order: got addr=%0d data=%h, required addr=%0d data=%h", rf_waddr, rf_wdata, mon_e.a, mon_e.d);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pipe(input logic we, input logic [4:0] a, input logic [31:0] d);
    pipe_we = we;
    pipe_addr = a;
    pipe_data = d;
    exp_pipe = we && a != 5'd0;
  endtask

  task automatic drive_mc(input logic v, input logic [4:0] a, input logic [31:0] d, input logic expect_retire);
    mc_valid = v;
    mc_addr = a;
    mc_data = d;
    if (v && expect_retire) sb.push_back('{a, d});
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL reset_rf_we: got %b, required 0", rf_we); end
    n_checks++; if (rf_waddr !== 5'd0) begin n_fail++; $display("FAIL reset_rf_waddr: got %0d, required 0", rf_waddr); end
    n_checks++; if (rf_wdata !== 32'd0) begin n_fail++; $display("FAIL reset_rf_wdata: got %h, required 0", rf_wdata); end
    n_checks++; if (mc_ready !== 1'b1) begin n_fail++; $display("FAIL reset_mc_ready: got %b, required 1", mc_ready); end
    n_checks++; if (mc_pending !== 1'b0) begin n_fail++; $display("FAIL reset_mc_pending: got %b, required 0", mc_pending); end
    n_checks++; if (stall_pipe !== 1'b0) begin n_fail++; $display("FAIL reset_stall_pipe: got %b, required 0", stall_pipe); end
  endtask

  task automatic test_pipe_only();
    tick();
    drive_pipe(1'b1, 5'd5, 32'hDEADBEEF);
    @(negedge clk);
    n_checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL pipe_write: got we=%b addr=%0d data=%h, required we=1 addr=5 data=deadbeef", rf_we, rf_waddr, rf_wdata);
    end
    tick();
    drive_pipe(1'b1, 5'd0, 32'h1234);
    @(negedge clk);
    n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL pipe_r0_dropped: got we=%b, required 0", rf_we); end
    tick();
    drive_pipe(1'b0, 5'd0, 32'd0);
  endtask

  task automatic test_idle_drain();
    tick();
    drive_mc(1'b1, 5'd3, 32'h11, 1'b1);
`ifndef RF_ARB_BYPASS_EN
    @(negedge clk);
    n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL drain_no_zero_latency: got we=%b, required 0", rf_we); end
`endif
    tick();
    drive_mc(1'b0, 5'd0, 32'd0, 1'b0);
`ifndef RF_ARB_BYPASS_EN
    @(negedge clk);
    n_checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'h11) begin
      n_fail++;
      $display("FAIL drain_retire: got we=%b addr=%0d data=%h, required we=1 addr=3 data=11", rf_we, rf_waddr, rf_wdata);
    end
    n_checks++; if (mc_pending !== 1'b1) begin n_fail++; $display("FAIL drain_pending_before: got %b, required 1", mc_pending); end
`endif
    tick();
    @(negedge clk);
    n_checks++; if (mc_pending !== 1'b0) begin n_fail++; $display("FAIL drain_pending_after: got %b, required 0", mc_pending); end
    n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL drain_outstanding: got %0d, required 0", sb.size()); end
  endtask

  task automatic test_full();
    tick();
    drive_pipe(1'b1, 5'd20, 32'hA0);
    drive_mc(1'b1, 5'd1, 32'h101, 1'b1);
    @(negedge clk);
    n_checks++; if (rf_waddr !== 5'd20) begin n_fail++; $display("FAIL full_pipe_prio0: got addr=%0d, required 20", rf_waddr); end
    tick();
    drive_pipe(1'b1, 5'd21, 32'hA1);
    drive_mc(1'b1, 5'd2, 32'h102, 1'b1);
    @(negedge clk);
    n_checks++; if (mc_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_one: got %b, required 1", mc_ready); end
    tick();
    drive_pipe(1'b1, 5'd22, 32'hA2);
    drive_mc(1'b1, 5'd4, 32'h104, 1'b1);
    @(negedge clk);
    n_checks++; if (mc_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready_low: got %b, required 0", mc_ready); end
    n_checks++; if (rf_waddr !== 5'd22 || rf_wdata !== 32'hA2) begin n_fail++; $display("FAIL full_pipe_prio2: got addr=%0d data=%h, required addr=22 data=a2", rf_waddr, rf_wdata); end
    tick();
    drive_pipe(1'b0, 5'd0, 32'd0);
    @(negedge clk);
    n_checks++; if (mc_ready !== 1'b0) begin n_fail++; $display("FAIL full_no_passthrough: got %b, required 0", mc_ready); end
    n_checks++; if (rf_waddr !== 5'd1) begin n_fail++; $display("FAIL full_first_out: got addr=%0d, required 1", rf_waddr); end
    tick();
    @(negedge clk);
    n_checks++; if (mc_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_after_pop: got %b, required 1", mc_ready); end
    tick();
    drive_mc(1'b0, 5'd0, 32'd0, 1'b0);
    tick();
    @(negedge clk);
    n_checks++; if (mc_pending !== 1'b0) begin n_fail++; $display("FAIL full_pending_end: got %b, required 0", mc_pending); end
    n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL full_outstanding: got %0d, required 0", sb.size()); end
  endtask

  task automatic test_starvation();
    tick();
    drive_pipe(1'b1, 5'd24, 32'hB0);
    drive_mc(1'b1, 5'd6, 32'h66, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      tick();
      drive_mc(1'b0, 5'd0, 32'd0, 1'b0);
      drive_pipe(1'b1, 5'(24 + k), 32'hB0 + 32'(k));
      @(negedge clk);
      n_checks++;
      if (stall_pipe !== 1'b0 || rf_waddr !== 5'(24 + k)) begin
        n_fail++;
        $display("FAIL starve_wait%0d: got stall=%b addr=%0d, required stall=0 addr=%0d", k, stall_pipe, rf_waddr, 24 + k);
      end
    end
    tick();
    drive_pipe(1'b1, 5'd30, 32'hBAD);
    exp_pipe = 1'b0;
    @(negedge clk);
    n_checks++; if (stall_pipe !== 1'b1) begin n_fail++; $display("FAIL starve_stall: got %b, required 1", stall_pipe); end
    n_checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd6 || rf_wdata !== 32'h66) begin
      n_fail++;
      $display("FAIL starve_head: got we=%b addr=%0d data=%h, required we=1 addr=6 data=66", rf_we, rf_waddr, rf_wdata);
    end
    tick();
    drive_pipe(1'b1, 5'd30, 32'hBAD);
    @(negedge clk);
    n_checks++; if (stall_pipe !== 1'b0) begin n_fail++; $display("FAIL starve_release: got %b, required 0", stall_pipe); end
    n_checks++; if (rf_waddr !== 5'd30 || rf_wdata !== 32'hBAD) begin n_fail++; $display("FAIL starve_replay: got addr=%0d data=%h, required addr=30 data=bad", rf_waddr, rf_wdata); end
    tick();
    drive_pipe(1'b0, 5'd0, 32'd0);
    @(negedge clk);
    n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL starve_outstanding: got %0d, required 0", sb.size()); end
  endtask

  task automatic test_r0_head();
    tick();
    drive_mc(1'b1, 5'd0, 32'h5, 1'b0);
    tick();
    drive_mc(1'b1, 5'd9, 32'h99, 1'b1);
`ifndef RF_ARB_BYPASS_EN
    @(negedge clk);
    n_checks++; if (rf_we !== 1'b0 || mc_pending !== 1'b1) begin n_fail++; $display("FAIL r0_head_silent: got we=%b pending=%b, required we=0 pending=1", rf_we, mc_pending); end
`endif
    tick();
    drive_mc(1'b0, 5'd0, 32'd0, 1'b0);
    tick();
    @(negedge clk);
    n_checks++; if (sb.size() != 0 || mc_pending !== 1'b0) begin n_fail++; $display("FAIL r0_head_drain: got outstanding=%0d pending=%b, required 0 and 0", sb.size(), mc_pending); end
  endtask

  task automatic test_reset_mid();
    tick();
    drive_pipe(1'b1, 5'd26, 32'hC0);
    drive_mc(1'b1, 5'd1, 32'hA1, 1'b0);
    tick();
    drive_pipe(1'b1, 5'd27, 32'hC1);
    drive_mc(1'b1, 5'd2, 32'hA2, 1'b0);
    tick();
    rst = 1'b1;
    drive_mc(1'b0, 5'd0, 32'd0, 1'b0);
    drive_pipe(1'b1, 5'd28, 32'hC2);
    @(negedge clk);
    n_checks++; if (rf_waddr !== 5'd28) begin n_fail++; $display("FAIL rstmid_pipe: got addr=%0d, required 28", rf_waddr); end
    tick();
    rst = 1'b0;
    drive_pipe(1'b0, 5'd0, 32'd0);
    @(negedge clk);
    n_checks++; if (mc_pending !== 1'b0) begin n_fail++; $display("FAIL rstmid_pending: got %b, required 0", mc_pending); end
    n_checks++; if (mc_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready: got %b, required 1", mc_ready); end
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_write%0d: got we=%b addr=%0d, required we=0", k, rf_we, rf_waddr); end
      tick();
      @(negedge clk);
    end
  endtask

`ifdef RF_ARB_BYPASS_EN
  task automatic test_bypass();
    tick();
    drive_mc(1'b1, 5'd7, 32'h42, 1'b1);
    @(negedge clk);
    n_checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'h42) begin n_fail++; $display("FAIL bypass_write: got we=%b addr=%0d data=%h, required we=1 addr=7 data=42", rf_we, rf_waddr, rf_wdata); end
    n_checks++; if (mc_ready !== 1'b1) begin n_fail++; $display("FAIL bypass_ready: got %b, required 1", mc_ready); end
    tick();
    drive_mc(1'b0, 5'd0, 32'd0, 1'b0);
    @(negedge clk);
    n_checks++; if (mc_pending !== 1'b0) begin n_fail++; $display("FAIL bypass_pending: got %b, required 0", mc_pending); end
  endtask
`endif

  initial begin
    test_reset();
    test_pipe_only();
    test_idle_drain();
    test_full();
    test_starvation();
    test_r0_head();
    test_reset_mid();
`ifdef RF_ARB_BYPASS_EN
    test_bypass();
`endif
    tick();
    n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL final_outstanding: got %0d, required 0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
